// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : vga_timing_gen_if
// Description : Pixel-side bundle between the raster timing stage and the
//               renderer / VGA pin driver.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
   logic       pix_en;
   logic [5:0] rgb_in;
   logic [9:0] x;
   logic [9:0] y;
   logic       de;
   logic       line_end;
   logic       frame_end;
   logic [5:0] rgb;
   logic       hs;
   logic       vs;

   // Timing generator side
   modport master (
      input  pix_en, rgb_in,
      output x, y, de, line_end, frame_end, rgb, hs, vs
   );

   // Renderer / consumer side
   modport slave (
      output pix_en, rgb_in,
      input  x, y, de, line_end, frame_end, rgb, hs, vs
   );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : vga_timing_gen
// Description : Raster timing generator. Two wrapping counters advance one
//               pixel per pix_en tick; coordinates, de and end-of-line/frame
//               pulses are decoded combinationally, while rgb/hs/vs are
//               registered so they trail x/y by exactly one pixel tick.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic              clk16M,
   input  logic              rst,
   vga_timing_gen_if.master  vga
);

   // Totals must not exceed 1024 so the 10-bit counters can hold them.
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Decode bounds are 11 bits wide so a sync window ending exactly at 1024
   // still compares correctly against the zero-extended 10-bit counters.
   localparam logic [10:0] C_H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] C_V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] C_H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] C_V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] C_HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] C_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] C_VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] C_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic [5:0] rgb_q, rgb_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;

   logic [10:0] w_h;
   logic [10:0] w_v;
   logic        w_h_last;
   logic        w_v_last;
   logic        w_de;
   logic        w_h_win;
   logic        w_v_win;

   // Pure decodes of the current counter position.
   always_comb begin
      w_h      = {1'b0, h_cnt_q};
      w_v      = {1'b0, v_cnt_q};
      w_h_last = (w_h == C_H_LAST);
      w_v_last = (w_v == C_V_LAST);
      w_de     = (w_h < C_H_ACT) && (w_v < C_V_ACT);
      w_h_win  = (w_h >= C_HS_START) && (w_h < C_HS_END);
      w_v_win  = (w_v >= C_VS_START) && (w_v < C_VS_END);
   end

   // Next state: everything holds unless this clock carries a pixel tick.
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      rgb_d   = rgb_q;
      hs_d    = hs_q;
      vs_d    = vs_q;
      if (vga.pix_en) begin
         hs_d  = w_h_win ? HS_POL : ~HS_POL;
         vs_d  = w_v_win ? VS_POL : ~VS_POL;
         rgb_d = w_de ? vga.rgb_in : 6'd0;
         if (w_h_last) begin
            h_cnt_d = 10'd0;
            v_cnt_d = w_v_last ? 10'd0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
      end
   end

   // State registers; reset wins over pix_en and parks the outputs idle.
   always_ff @(posedge clk16M) begin
      if (rst) begin
         h_cnt_q <= 10'd0;
         v_cnt_q <= 10'd0;
         rgb_q   <= 6'd0;
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         rgb_q   <= rgb_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
      end
   end

   assign vga.x         = h_cnt_q;
   assign vga.y         = v_cnt_q;
   assign vga.de        = w_de;
   assign vga.line_end  = vga.pix_en && w_h_last;
   assign vga.frame_end = vga.pix_en && w_h_last && w_v_last;
   assign vga.rgb       = rgb_q;
   assign vga.hs        = hs_q;
   assign vga.vs        = vs_q;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing stage between the game/render logic and the VGA pins of top_level.
- Generates horizontal and vertical counters, pixel coordinates and the data-enable for the renderer.
- Accepts the renderer's 6-bit colour for the current coordinate and drives registered, blank-gated rgb with aligned hs/vs.
- Advances one pixel per clock on which pix_en is high, so one clk16M domain serves any pixel rate.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hs level during sync pulse (0 = active-low)
VS_POL, 0, vs level during sync pulse

Ports:
clk16M  in  1  system clock
rst  in  1  synchronous reset, active-high
pix_en  in  1  pixel tick; counters and outputs advance only when high
rgb_in  in  6  renderer colour for current x/y (2 bits each R,G,B)
x  out  10  current horizontal count (h_cnt)
y  out  10  current vertical count (v_cnt)
de  out  1  current x/y inside active area
line_end  out  1  one-clk pulse on last pixel tick of a line
frame_end  out  1  one-clk pulse on last pixel tick of a frame
rgb  out  6  registered colour to DAC
hs  out  1  registered horizontal sync
vs  out  1  registered vertical sync

Behaviour:
- Interface: one clock, clk16M; rst synchronous, active-high.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). Both must be ≤ 1024.
- Horizontal counter: on clk with pix_en=1, h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
- Vertical counter: v_cnt wraps to 0 when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
- pix_en=0: all registers hold and line_end/frame_end are 0.
- x=h_cnt, y=v_cnt, combinational from the counters. de=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
- line_end=pix_en&&h_cnt==H_TOTAL-1. frame_end=line_end&&v_cnt==V_TOTAL-1. Combinational, therefore a single clk wide.
- Sync windows:
  - h sync window: H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - v sync window: V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC.
- Output stage: on pix_en=1, these values are registered from the current counters and rgb_in:
  - hs <= in h window ? HS_POL : ~HS_POL
  - vs <= in v window ? VS_POL : ~VS_POL
  - rgb <= de ? rgb_in : 6'b0
- Latency: hs/vs/rgb lag x/y by exactly one pixel tick and are mutually aligned. rgb_in is sampled in the same clk as the coordinate it belongs to; the renderer must be combinational or pre-fetched.
- Reset state: h_cnt=0, v_cnt=0, rgb=0, hs=~HS_POL, vs=~VS_POL.
  - During and after reset: x=0, y=0, de=1, line_end=0, frame_end=0.
- Reset mid-frame: the counter restarts at (0,0) on the clk after rst is sampled high. No partial pulse survives reset.
- rst has priority over pix_en.
- Blanking region: rgb_in is ignored and rgb is forced to 0 even if rgb_in≠0.
- No other state; no FSM beyond the two wrapping counters. The sync windows are pure decodes.

Test Plan:
- Reset/idle: rst=1 for 5 clk with pix_en=1 → x=0, y=0, hs=1, vs=1, rgb=0. After release, x=1 on the first clk with pix_en.
- Line timing (defaults, pix_en=1 every clk):
  - line_end pulses every 800 clk.
  - hs low for exactly 96 ticks, first low at the tick following h_cnt=656.
  - de high 640 of every 800 ticks.
- Frame timing: frame_end every 800*525=420000 clk. vs low for 1600 ticks, starting one tick after (h=0, v=490).
- Blanking and alignment: rgb_in=6'h3F constant → rgb=6'h3F exactly while delayed de=1, 0 elsewhere. rgb_in=x[5:0] → rgb equals the previous tick's x.
- Pixel enable: pix_en high every 2nd clk → all periods double (line_end every 1600 clk). Outputs frozen on clocks with pix_en=0.
- Mid-operation reset and small geometry: with H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, assert rst at (h=5, v=4) → next clk x=0, y=0, hs=1, vs=1. frame_end recurs every 48 ticks.
